// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and state encoding for the channel-mux scan controller,
// its output register and its bench.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH  = 31;
  localparam int SEL_W   = 5;
  localparam int DATA_W  = 2;
  localparam int LAST_CH = NUM_CH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan-controller bus: start/mask request, mux select/data, beat output and status.
interface mux_scan_ctrl_if;
  import mux_scan_ctrl_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] chan_en;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_out;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_chan;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    output start, chan_en, mux_out, out_ready,
    input  sel, out_valid, out_chan, out_data, busy, done
  );

  modport slave (
    input  start, chan_en, mux_out, out_ready,
    output sel, out_valid, out_chan, out_data, busy, done
  );

endinterface

// File: rtl/mux_scan_ctrl_scan_out_reg.sv
// Single-entry valid/ready holding register for captured (channel, data) beats.
module scan_out_reg
  import mux_scan_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [SEL_W-1:0]  i_chan,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_can_load,
  output logic              o_valid,
  output logic [SEL_W-1:0]  o_chan,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [SEL_W-1:0]  r_chan;
  logic [DATA_W-1:0] r_data;

  // A beat leaving on this edge frees the slot for a same-edge capture.
  assign o_can_load = !r_valid || i_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_chan  <= i_chan;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_chan  = r_chan;
  assign o_data  = r_data;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer: steps the mux select over the enabled channels and emits
// one (channel, data) beat per enabled channel, then pulses done.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mux_scan_ctrl_if.slave bus
);

  state_t            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_CH-1:0] r_en;

  logic [NUM_CH-1:0] w_hit;
  logic              w_ch_en;
  logic              w_last;
  logic              w_can_load;
  logic              w_load;
  logic              w_advance;

  // One-hot match of the current select against the latched mask.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
      assign w_hit[gi] = r_en[gi] && (r_sel == SEL_W'(gi));
    end
  endgenerate

  assign w_ch_en   = |w_hit;
  assign w_last    = (r_sel == SEL_W'(LAST_CH));
  assign w_load    = (r_state == ST_SCAN) && w_ch_en && w_can_load;
  assign w_advance = (r_state == ST_SCAN) && (!w_ch_en || w_can_load);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_en    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_en    <= bus.chan_en;
            r_sel   <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_advance) begin
            if (w_last) begin
              r_sel   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_sel <= r_sel + 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  scan_out_reg u_out (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_chan     (r_sel),
    .i_data     (bus.mux_out),
    .i_ready    (bus.out_ready),
    .o_can_load (w_can_load),
    .o_valid    (bus.out_valid),
    .o_chan     (bus.out_chan),
    .o_data     (bus.out_data)
  );

  assign bus.sel  = r_sel;
  assign bus.busy = (r_state == ST_SCAN);
  assign bus.done = (r_state == ST_DONE);

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Upstream sequencer for the 31-input, 2-bit channel mux. On a start pulse it drives the mux select through channels 0..30 and skips any channel masked off in the enable vector. For each enabled channel it captures the mux output into a single-entry output register. Captured results leave as (channel, data) beats on a valid/ready interface, and a done pulse marks the end of the scan.

Parameters:
NUM_CH, 31, number of mux channels scanned; legal select values are 0..NUM_CH-1.
SEL_W, 5, select and channel-index width.
DATA_W, 2, mux data width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a scan; ignored unless idle
chan_en  input  NUM_CH  per-channel enable mask; sampled on accepted start
sel  output  SEL_W  registered select, drives the mux select input
mux_out  input  DATA_W  combinational output of the mux for the current sel
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts the beat
out_chan  output  SEL_W  channel index of the beat
out_data  output  DATA_W  captured mux data
busy  output  1  high while in SCAN
done  output  1  one-cycle pulse after the last channel is processed

Behaviour:
- Reset is asynchronous, active-high, and applies mid-scan as well. It sets state=IDLE, sel=0, out_valid=0, out_chan=0, out_data=0, busy=0, done=0 and clears the latched mask. Any in-flight beat is lost.
- FSM states: IDLE, SCAN, DONE.
- IDLE with start=1 at an edge: latch en_q<=chan_en, sel<=0, go to SCAN.
- start while in SCAN or DONE is ignored.
- Edge in SCAN with sel=k:
  - Channel k is processed if en_q[k]=0, or if en_q[k]=1 and the output register can load.
  - Can load = !out_valid || out_ready.
  - Enabled and can load: out_data<=mux_out, out_chan<=k, out_valid<=1.
  - Disabled: no capture; the channel takes one cycle to skip.
  - Enabled and cannot load: stall. sel holds, nothing captured, mux_out is re-sampled on a later edge.
  - Processed with k<NUM_CH-1: sel<=k+1.
  - Processed with k=NUM_CH-1: sel<=0, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- sel never takes the value 31. sel=31 is not a data channel; the mux returns 0 there.
- Output handshake:
  - A beat transfers when out_valid && out_ready.
  - out_valid drops after a transfer unless a new capture happens on the same edge. A same-edge capture replaces the beat, giving back-to-back beats.
  - out_chan and out_data stay stable while out_valid=1 && out_ready=0.
- The final beat may still be pending after done. It drains normally, and a new scan cannot overwrite it because of the load rule.
- Latency: the beat for channel k is valid the cycle after the edge at which sel=k was processed.
- Scan length with out_ready held high: 31 edges in SCAN regardless of mask, plus 1 cycle in DONE.
- Mask all zero: 31 cycles of skipping, no beats, done still pulses.
- busy = (state==SCAN). done = (state==DONE). Both are derived from registered state, so neither has a combinational path from any input.
- The mask is frozen during a scan; changes on chan_en take effect only at the next accepted start.

Decomposition:
- Shared package: state encoding (IDLE/SCAN/DONE), NUM_CH, SEL_W, DATA_W, and the constant LAST_CH = NUM_CH-1. The mux and its bench use the same package.
- One sub-module is natural: scan_out_reg, the single-entry valid/ready output holding register with load and can-load logic. The FSM and select counter stay in the top.

Test Plan:
- Mask all ones, inp_k = k mod 4, out_ready=1, start at cycle 0 -> beats ch0..ch30 on consecutive cycles starting cycle 2, data = k mod 4; done in cycle 32; busy high cycles 1..31.
- Mask 0x0000_0005 (ch0, ch2), inp0=3, inp2=1 -> exactly two beats, (0,3) then (2,1); ch1 and ch3..30 are skipped one cycle each; done still in cycle 32.
- Mask all ones, out_ready low for 5 cycles after the first beat -> sel holds at 1; beat (0,x) holds stable; on release, ch1 captures and the sequence resumes with no channel lost or duplicated.
- Mask all zero -> no out_valid ever; done pulses once after 31 SCAN cycles; sel returns to 0.
- start pulsed again mid-scan and chan_en changed mid-scan -> ignored; the beat set matches the mask latched at the original start.
- reset asserted asynchronously mid-scan with out_valid=1 -> in the same cycle all outputs are 0 and state is IDLE; a subsequent start performs a full clean scan.
